// File: rtl/mau_pkg.sv
// mem_access_unit shared types: size codes, FSM states, byte-enable masks.
// Imported by mem_access_unit and mau_lane_fmt.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_B0  = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_e;

  // Fetches and the spare 2'b10 code both act as word accesses.
  function automatic logic [1:0] norm_size(
    input logic       fetch,
    input logic [1:0] sz
  );
    return (fetch || sz == 2'b10) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/mau_lane_fmt.sv
// Combinational lane logic: store steering and load extraction.
// Store side uses the incoming request, load side the latched one.
module mau_lane_fmt
  import mau_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [4:0]  rot_sh;
  logic [63:0] rot_dbl;
  logic [31:0] rot;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Replicate store data across lanes and pick byte enables.
  always_comb begin
    st_wdata_o = st_wdata_i;
    st_be      = BE_ALL;
    unique case (st_size)
      SZ_BYTE: begin
        st_wdata_o = {4{st_wdata_i[7:0]}};
        st_be      = BE_B0 << st_off;
      end
      SZ_HALF: begin
        st_wdata_o = {2{st_wdata_i[15:0]}};
        st_be      = st_off[1] ? BE_HI : BE_LO;
      end
      default: ;
    endcase
  end

  // Rotate word by the byte offset, select lane, then extend.
  always_comb begin
    rot_sh  = {ld_off, 3'b000};
    rot_dbl = {ld_rdata, ld_rdata} >> rot_sh;
    rot     = rot_dbl[31:0];
    ld_b    = rot[7:0];
    ld_h    = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = rot;
    unique case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_b[7]}}, ld_b};
      SZ_HALF: ld_data = {{16{ld_signed & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: IDLE/BUS/RESP FSM, bus watchdog, registered outputs.
// Optional ALIGN_FAULT_EN: misaligned half/word requests fault without bus.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_fetch,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]  in_size;
  logic        in_sgn;
  logic        fault;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  mau_lane_fmt u_fmt (
    .st_size    (in_size),
    .st_off     (req_addr[1:0]),
    .st_wdata_i (req_wdata),
    .st_wdata_o (st_wdata),
    .st_be      (st_be),
    .ld_size    (size_q),
    .ld_off     (off_q),
    .ld_signed  (sgn_q),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data)
  );

  // Normalise the incoming request and decide alignment fault.
  always_comb begin
    in_size = norm_size(req_fetch, req_size);
    in_sgn  = req_signed & ~req_fetch & ~req_we & (in_size != SZ_WORD);
`ifdef ALIGN_FAULT_EN
    fault = (in_size == SZ_HALF && req_addr[0]) ||
            (in_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
    fault = 1'b0;
`endif
  end

  // Next-state, watchdog and registered-output computation.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d      = in_size;
          sgn_d       = in_sgn;
          off_d       = req_addr[1:0];
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = req_we ? st_be : BE_ALL;
          mem_wdata_d = req_we ? st_wdata : 32'h0;
          tmo_d       = '0;
          if (fault) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d   = ST_BUS;
            mem_req_d = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mem_we_q ? 32'h0 : ld_data;
          tmo_d       = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
          tmo_d       = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      size_q      <= SZ_WORD;
      sgn_q       <= 1'b0;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential, parametrised load/store access unit between the ARMv4 core's data path and the single-port memory bus. It accepts one access request at a time from the core and drives a registered word-aligned bus request with byte enables. It holds that request through memory wait states, with a timeout watchdog, then returns a single-cycle response. For loads the response carries byte, halfword or rotated word data with zero or sign extension.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of request and bus addresses
- TMO_W, 8, width of wait-state watchdog counter
- TMO_CYC, 255, bus cycles without `mem_ack` before timeout (must fit in TMO_W, ≥1)

Ports (clock, reset first; one clock; reset is asynchronous, active-low):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_fetch  in  1  instruction fetch: forces word, unsigned
- req_size  in  2  00 byte, 01 halfword, 11 word, 10 treated as word
- req_signed  in  1  sign-extend load data (ignored for word/fetch/store)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  formatted load data; 0 for stores and errors
- rsp_err  out  1  timeout (or alignment fault, see Configuration)
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned address (`req_addr` with bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered store data
- mem_rdata  in  32  bus read data, valid with `mem_ack`
- mem_ack  in  1  bus completion

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: `req_ready` = 1. On `req_valid` the request is latched: we, size (fetch → word/unsigned), signed, addr[1:0], bus fields. Next state BUS, or RESP under alignment fault.
- BUS: `mem_req` = 1 with stable `mem_*`.
  - `mem_ack` → capture formatted data, go to RESP.
  - Otherwise the watchdog increments. When it reaches TMO_CYC: `mem_req` drops, `rsp_err` = 1, go to RESP.
- RESP: `rsp_valid` = 1 for exactly one cycle, then IDLE. No response backpressure.
- `mem_ack` outside BUS is ignored, including a late ack after a timeout.
- Store steering:
  - byte: `mem_wdata` = wdata[7:0] replicated ×4; `mem_be` = 1 << addr[1:0].
  - halfword: wdata[15:0] replicated ×2; `mem_be` = addr[1] ? 1100 : 0011.
  - word: `mem_wdata` = wdata; `mem_be` = 1111.
- Load be: `mem_be` = 1111 always.
- Load formatting:
  - byte lane = addr[1:0].
  - halfword lane = addr[1].
  - Word data is rotated right by 8·addr[1:0] (ARMv4 LDR).
  - Byte/halfword results are zero- or sign-extended per latched signed flag.
- Without ALIGN_FAULT_EN, halfword addr[0] is ignored.

## Timing
- Reset values: state IDLE (`req_ready` = 1), `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_be` 0, `mem_wdata` 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, watchdog 0.
- Accept in cycle N. `mem_req` is high from N+1. Ack in cycle N+k gives `rsp_valid` in N+k+1. Minimum latency is 2 cycles, and throughput is one access per 3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_ack`/`mem_rdata` to `rsp_*`.
- Timeout: with no ack, `mem_req` is high for TMO_CYC cycles (N+1..N+TMO_CYC) and `rsp_valid`/`rsp_err` assert at N+TMO_CYC+1.
- An ack in the same cycle the watchdog hits TMO_CYC wins: normal response, `rsp_err` = 0.
- Reset mid-operation: `mem_req` and `rsp_valid` drop immediately. The transaction is discarded and no response is issued.

## Configuration
- ALIGN_FAULT_EN defined:
  - Faulting requests: a halfword with addr[0] = 1, or a word (non-fetch) with addr[1:0] ≠ 0.
  - A faulting request skips BUS and never asserts `mem_req`. It responds at N+1 with `rsp_err` = 1 and `rsp_rdata` = 0.
  - A fetch with addr[1:0] ≠ 0 faults as well.
- Undefined: there are no alignment faults. Misaligned word loads rotate, misaligned word stores/fetches are aligned down, and halfword addr[0] is ignored.

## Structure
- Shared package `mau_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, lane/byte-enable helper constants.
- Sub-module `mau_lane_fmt`: purely combinational.
  - Store steering (wdata, be from size/addr).
  - Load extraction (rotate, select, sign/zero extend).
  - Instantiated once; FSM and watchdog live in `mem_access_unit`.

## Test plan
- Signed byte load, addr 0x1003, `mem_rdata` 0x80FF_1234, ack at N+1 → `rsp_valid` at N+2, `rsp_rdata` 0xFFFF_FF80, `mem_addr` 0x1000, `rsp_err` 0.
- Unsigned halfword load, addr 0x2002, `mem_rdata` 0xBEEF_0001, 3 wait states → `rsp_rdata` 0x0000_BEEF at N+5.
- Word load, addr 0x3001, `mem_rdata` 0x4433_2211, ALIGN_FAULT_EN off → `rsp_rdata` 0x1144_3322. With it on → no `mem_req`, `rsp_err` = 1 at N+1.
- Byte store, addr 0x4002, wdata 0x0000_00AB → `mem_be` 0100, `mem_wdata` 0xABAB_ABAB, `mem_we` 1.
- TMO_CYC = 4, no ack → `mem_req` high exactly 4 cycles, `rsp_err` = 1, `rsp_rdata` 0. A late ack in IDLE is ignored.
- `rst_n` low during BUS wait → `mem_req`/`rsp_valid` 0 immediately, `req_ready` 1 after release, next request completes normally.
